fwd_hazard_ctrl: RTL and testbench

// - Pipeline forwarding/hazard controller for the 5-stage CPU. Generates the 2-bit

---
 rtl/fwd_hazard_ctrl_pkg.sv | 11 +
 rtl/fwd_hazard_ctrl_sel.sv | 23 ++
 rtl/fwd_hazard_ctrl.sv | 111 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants for the EX forwarding selects and the load-use stall FSM.
package fwd_hazard_ctrl_pkg;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

endpackage

// File: rtl/fwd_hazard_ctrl_sel.sv
// Per-operand forwarding select: EX/MEM result beats MEM/WB, register 0 never forwards.
module fwd_sel_calc
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  output logic [1:0]        sel
);

  always_comb begin
    sel = SEL_REG;
    if (mem_we && (mem_rd != '0) && (mem_rd == src))
      sel = SEL_MEM;
    else if (wb_we && (wb_rd != '0) && (wb_rd == src))
      sel = SEL_WB;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard controller: shadows EX/MEM/WB control, drives EX mux selects
// and stalls PC/IF-ID for LOAD_STALL cycles on a load-use hazard.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              bubble_o
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              memread;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } ex_stage_t;

  typedef struct packed {
    logic              regwrite;
    logic [REG_AW-1:0] rd;
  } wr_stage_t;

  localparam bit         MULTI    = (LOAD_STALL > 1);
  localparam logic [1:0] CNT_INIT = 2'(LOAD_STALL - 1);

  ex_stage_t  ex_q, id_s;
  wr_stage_t  mem_q, wb_q;
  logic [0:0] state_q;
  logic [1:0] cnt_q;
  logic       hz, stall, last;
  logic [1:0] sel_a, sel_b;

  always_comb begin
    id_s = '{valid: 1'b1, regwrite: id_regwrite_i, memread: id_memread_i,
             rs: id_rs_i, rt: id_rt_i, rd: id_rd_i};
    hz = id_valid_i && ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
         ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i));
    stall = !flush_i && ((state_q == ST_STALL) || hz);
    // cnt_q counts the stall cycles still owed including the current one
    last  = (state_q == ST_STALL) ? (cnt_q == 2'd1) : !MULTI;
  end

  assign pc_write_o   = !stall;
  assign ifid_write_o = !stall;
  assign bubble_o     = stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (flush_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (state_q == ST_RUN) begin
      if (hz && MULTI) begin
        state_q <= ST_STALL;
        cnt_q   <= CNT_INIT;
      end
    end else begin
      if (cnt_q == 2'd1) state_q <= ST_RUN;
      cnt_q <= cnt_q - 2'd1;
    end
  end

  // The load stays in EX through all but the last bubble; MEM drains meanwhile.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q <= mem_q;
      if (stall && !last) begin
        mem_q <= '0;
      end else begin
        mem_q <= '{regwrite: ex_q.regwrite, rd: ex_q.rd};
        ex_q  <= (id_valid_i && !stall && !flush_i) ? id_s : '0;
      end
    end
  end

  fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_a (
    .src(ex_q.rs), .mem_rd(mem_q.rd), .mem_we(mem_q.regwrite),
    .wb_rd(wb_q.rd), .wb_we(wb_q.regwrite), .sel(sel_a)
  );

  fwd_sel_calc #(.REG_AW(REG_AW)) u_sel_b (
    .src(ex_q.rt), .mem_rd(mem_q.rd), .mem_we(mem_q.regwrite),
    .wb_rd(wb_q.rd), .wb_we(wb_q.regwrite), .sel(sel_b)
  );

  assign fwd_a_sel_o = ex_q.valid ? sel_a : SEL_REG;
  assign fwd_b_sel_o = ex_q.valid ? sel_b : SEL_REG;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench: two controllers (LOAD_STALL=1 and 2) share stimulus and are
// checked against an instruction-level pipeline model.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv, iwe, imr, ifl;
  logic [4:0] irs, irt, ird;
  logic [1:0] a [2];
  logic [1:0] b [2];
  logic       pcw [2];
  logic       ifw [2];
  logic       bub [2];

  fwd_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(iv), .id_rs_i(irs), .id_rt_i(irt),
    .id_rd_i(ird), .id_regwrite_i(iwe), .id_memread_i(imr), .flush_i(ifl),
    .fwd_a_sel_o(a[0]), .fwd_b_sel_o(b[0]), .pc_write_o(pcw[0]),
    .ifid_write_o(ifw[0]), .bubble_o(bub[0])
  );

  fwd_hazard_ctrl #(.REG_AW(5), .LOAD_STALL(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(iv), .id_rs_i(irs), .id_rt_i(irt),
    .id_rd_i(ird), .id_regwrite_i(iwe), .id_memread_i(imr), .flush_i(ifl),
    .fwd_a_sel_o(a[1]), .fwd_b_sel_o(b[1]), .pc_write_o(pcw[1]),
    .ifid_write_o(ifw[1]), .bubble_o(bub[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: instructions in flight ----------------
  typedef struct {
    bit v, we, mr;
    int rs, rt, rd;
  } slot_t;

  typedef struct {
    logic [1:0] a, b;
    logic       pcw, ifw, bub;
  } exp_t;

  slot_t ex [2];
  slot_t mem [2];
  slot_t wb [2];
  int    left [2];
  int    ls_of [2] = '{1, 2};
  exp_t  q0 [$];
  exp_t  q1 [$];

  function automatic bit m_stall(input int d);
    bit hz;
    hz = iv && ex[d].v && ex[d].mr && ex[d].rd != 0 &&
         (ex[d].rd == int'(irs) || ex[d].rd == int'(irt));
    return !ifl && (left[d] > 0 || hz);
  endfunction

  function automatic int m_sel(input int d, input int src);
    if (!ex[d].v) return 0;
    if (mem[d].we && mem[d].rd != 0 && mem[d].rd == src) return 2;
    if (wb[d].we && wb[d].rd != 0 && wb[d].rd == src) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ex[d] = '{default: 0}; mem[d] = '{default: 0}; wb[d] = '{default: 0};
      left[d] = 0;
    end
  endtask

  task automatic model_step();
    slot_t bb, id;
    bit    st;
    int    rem;
    bb = '{default: 0};
    id = '{v: 1, we: iwe, mr: imr, rs: int'(irs), rt: int'(irt), rd: int'(ird)};
    for (int d = 0; d < 2; d++) begin
      st = m_stall(d);
      wb[d] = mem[d];
      if (ifl) begin
        left[d] = 0; mem[d] = ex[d]; ex[d] = bb;
      end else if (st) begin
        rem = ((left[d] > 0) ? left[d] : ls_of[d]) - 1;
        left[d] = rem;
        if (rem == 0) begin mem[d] = ex[d]; ex[d] = bb; end
        else mem[d] = bb;
      end else begin
        mem[d] = ex[d];
        ex[d] = iv ? id : bb;
      end
    end
  endtask

  task automatic drive(input bit v, input int rs, input int rt, input int rd,
                       input bit we, input bit mr, input bit fl);
    exp_t e;
    bit   st;
    @(negedge clk);
    iv = v; irs = 5'(rs); irt = 5'(rt); ird = 5'(rd); iwe = we; imr = mr; ifl = fl;
    #1;
    for (int d = 0; d < 2; d++) begin
      st = m_stall(d);
      e.a = 2'(m_sel(d, ex[d].rs)); e.b = 2'(m_sel(d, ex[d].rt));
      e.pcw = !st; e.ifw = !st; e.bub = st;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
  endtask

  task automatic cyc(input bit v, input int rs, input int rt, input int rd,
                     input bit we, input bit mr, input bit fl);
    drive(v, rs, rt, rd, we, mr, fl);
    step();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmp_out(input int d, input exp_t e);
    chk2($sformatf("sb%0d_fwd_a", d), a[d], e.a);
    chk2($sformatf("sb%0d_fwd_b", d), b[d], e.b);
    chk1($sformatf("sb%0d_pc_write", d), pcw[d], e.pcw);
    chk1($sformatf("sb%0d_ifid_write", d), ifw[d], e.ifw);
    chk1($sformatf("sb%0d_bubble", d), bub[d], e.bub);
  endtask

  // monitor: pops whatever expectation the stimulus side left for this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q0.size() > 0) begin e = q0.pop_front(); cmp_out(0, e); end
      if (q1.size() > 0) begin e = q1.pop_front(); cmp_out(1, e); end
    end
  end

  task automatic chk_reset_outs(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk2($sformatf("%s%0d_a", nm, d), a[d], 2'b00);
      chk2($sformatf("%s%0d_b", nm, d), b[d], 2'b00);
      chk1($sformatf("%s%0d_pcw", nm, d), pcw[d], 1'b1);
      chk1($sformatf("%s%0d_ifw", nm, d), ifw[d], 1'b1);
      chk1($sformatf("%s%0d_bub", nm, d), bub[d], 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    iv = 0; irs = 0; irt = 0; ird = 0; iwe = 0; imr = 0; ifl = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk_reset_outs("in_reset");
    rst = 1'b0;

    idle(); chk_reset_outs("idle"); step();

    // add $3,$1,$2 ; sub $4,$3,$5
    cyc(1, 1, 2, 3, 1, 0, 0); cyc(1, 3, 5, 4, 1, 0, 0);
    idle(); chk2("ex_mem_a", a[0], 2'b10); chk2("ex_mem_b", b[0], 2'b00); step();

    // add $3 ; nop ; and $6,$5,$3
    cyc(1, 1, 2, 3, 1, 0, 0); cyc(0, 0, 0, 0, 0, 0, 0); cyc(1, 5, 3, 6, 1, 0, 0);
    idle(); chk2("mem_wb_b", b[0], 2'b01); chk2("mem_wb_a", a[0], 2'b00); step();

    // same with dest $0
    cyc(1, 1, 2, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0, 0, 0); cyc(1, 5, 0, 6, 1, 0, 0);
    idle(); chk2("reg0_b", b[0], 2'b00); step();

    // add $3 ; add $3 ; or $7,$3,$3
    cyc(1, 1, 2, 3, 1, 0, 0); cyc(1, 4, 5, 3, 1, 0, 0); cyc(1, 3, 3, 7, 1, 0, 0);
    idle(); chk2("newest_a", a[0], 2'b10); chk2("newest_b", b[0], 2'b10); step();

    // lw $2 ; add $4,$2,$1 (ID re-presents add while held)
    cyc(1, 5, 6, 2, 1, 1, 0);
    drive(1, 2, 1, 4, 1, 0, 0);
    for (int d = 0; d < 2; d++) begin
      chk1($sformatf("lu_stall%0d_pcw", d), pcw[d], 1'b0);
      chk1($sformatf("lu_stall%0d_bub", d), bub[d], 1'b1);
    end
    step();
    drive(1, 2, 1, 4, 1, 0, 0);
    chk1("ls1_release_pcw", pcw[0], 1'b1); chk1("ls2_second_bubble", bub[1], 1'b1); step();
    drive(1, 2, 1, 4, 1, 0, 0);
    chk2("ls1_load_fwd_a", a[0], 2'b01); chk1("ls2_release_pcw", pcw[1], 1'b1); step();
    idle(); chk2("ls2_load_fwd_a", a[1], 2'b01); step();

    // lw $2 ; add $4,$2,$1 squashed by flush in the hazard cycle
    cyc(1, 5, 6, 2, 1, 1, 0);
    drive(1, 2, 1, 4, 1, 0, 1);
    for (int d = 0; d < 2; d++) chk1($sformatf("flush%0d_pcw", d), pcw[d], 1'b1);
    step();
    idle();
    for (int d = 0; d < 2; d++) chk2($sformatf("flush%0d_ex_bubble", d), a[d], 2'b00);
    step();

    // reset asserted while LOAD_STALL=2 instance sits in STALL
    cyc(1, 5, 6, 2, 1, 1, 0);
    cyc(1, 2, 1, 4, 1, 0, 0);
    @(negedge clk);
    #1 chk1("pre_reset_stall", pcw[1], 1'b0);
    rst = 1'b1;
    #1 chk_reset_outs("mid_stall_reset");
    iv = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // randomized traffic over a small register window to provoke hazards
    repeat (600) begin
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3,
          $urandom_range(0, 11) == 0);
    end
    idle(); step();

    repeat (3) @(negedge clk);
    chk1("sb_drained", (q0.size() == 0) && (q1.size() == 0), 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
